// File: rtl/rss_gain_normalizer_pkg.sv
// Shared definitions for the RSS gain normalizer.
// Holds the default widths, the control state enum and the saturating
// narrow helper used by both the gain path and the sample scaling path.
package rss_gain_normalizer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FRAC_W = 16;
    // Numerator width of the gain division: target << FRAC_W
    localparam int unsigned NUM_W  = DATA_W + FRAC_W;
    // Product width with one spare bit so the rounding add cannot wrap
    localparam int unsigned WIDE_W = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        LOAD   = 2'd2,
        EMIT   = 2'd3
    } state_t;

    // Clamp a wide unsigned value to DATA_W bits (all-ones on overflow)
    function automatic logic [DATA_W-1:0] sat_narrow(input logic [WIDE_W-1:0] value);
        if (|value[WIDE_W-1:DATA_W]) begin
            return '1;
        end
        return value[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// The first iteration is performed on the start edge itself, so a full
// NUM_W-bit quotient is ready NUM_W-1 edges later and done pulses in the
// cycle right after the final iteration.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : load numerator/denominator and begin (ignored while running)
//   numerator    : NUM_W-bit dividend
//   denominator  : DEN_W-bit divisor (caller guarantees nonzero)
//   done         : one-cycle pulse, quotient valid from this cycle on
//   quotient     : full NUM_W-bit quotient, held until the next start
module seq_restoring_divider
    import rss_gain_normalizer_pkg::*;
#(
    parameter int unsigned NUM_W_P = NUM_W,
    parameter int unsigned DEN_W_P = DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_W_P-1:0] numerator,
    input  logic [DEN_W_P-1:0] denominator,
    output logic               done,
    output logic [NUM_W_P-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(NUM_W_P + 1);

    logic               running;
    logic [CNT_W-1:0]   cnt;
    logic [DEN_W_P-1:0] rem_q;
    logic [DEN_W_P-1:0] den_q;
    // Dividend bits shift out at the top while quotient bits shift in below
    logic [NUM_W_P-1:0] acc_q;

    logic               load_c;
    logic [DEN_W_P-1:0] rem_src_c;
    logic [DEN_W_P-1:0] den_src_c;
    logic [NUM_W_P-1:0] acc_src_c;
    logic [DEN_W_P:0]   trial_c;
    logic               fits_c;
    logic [DEN_W_P-1:0] rem_nxt_c;
    logic [NUM_W_P-1:0] acc_nxt_c;

    // One restoring step; on load it works straight from the port operands
    always_comb begin
        load_c    = start && !running;
        rem_src_c = load_c ? '0 : rem_q;
        den_src_c = load_c ? denominator : den_q;
        acc_src_c = load_c ? numerator : acc_q;
        trial_c   = {rem_src_c, acc_src_c[NUM_W_P-1]};
        fits_c    = trial_c >= {1'b0, den_src_c};
        rem_nxt_c = fits_c ? DEN_W_P'(trial_c - {1'b0, den_src_c}) : DEN_W_P'(trial_c);
        acc_nxt_c = {acc_src_c[NUM_W_P-2:0], fits_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            acc_q   <= '0;
        end else begin
            done <= 1'b0;
            if (load_c) begin
                running <= 1'b1;
                den_q   <= denominator;
                rem_q   <= rem_nxt_c;
                acc_q   <= acc_nxt_c;
                cnt     <= CNT_W'(NUM_W_P - 1);
            end else if (running) begin
                rem_q <= rem_nxt_c;
                acc_q <= acc_nxt_c;
                cnt   <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient = acc_q;

endmodule

// File: rtl/rss_gain_normalizer.sv
// Rescales a four-sample frame so its RSS magnitude matches a target level.
// gain = sat((target << FRAC_W) / magnitude), unsigned Q16.16 at defaults;
// each sample is scaled as sat((s * gain) >> FRAC_W) and emitted serially.
// Optional build macro: RSS_GAIN_ROUND_EN (round half up in the scaling).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid / in_ready    : frame input handshake (ready only in IDLE)
//   sample0..sample3       : frame samples
//   magnitude, target      : frame RSS magnitude and desired magnitude
//   out_valid / out_ready  : scaled sample output handshake
//   out_sample             : scaled sample
//   out_index, out_last    : sample position 0..3, last flag at index 3
//   busy                   : any state other than IDLE
module rss_gain_normalizer
    import rss_gain_normalizer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] sample0,
    input  logic [DATA_W-1:0] sample1,
    input  logic [DATA_W-1:0] sample2,
    input  logic [DATA_W-1:0] sample3,
    input  logic [DATA_W-1:0] magnitude,
    input  logic [DATA_W-1:0] target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sample,
    output logic [1:0]        out_index,
    output logic              out_last,
    output logic              busy
);

`ifdef RSS_GAIN_ROUND_EN
    localparam int unsigned ROUND_HALF = 1 << (FRAC_W - 1);
`endif

    state_t                 state;
    logic [3:0][DATA_W-1:0] frame_q;
    logic [DATA_W-1:0]      gain_q;

    logic                   accept_c;
    logic                   div_start_c;
    logic                   div_done;
    logic [NUM_W-1:0]       div_quotient;
    logic [1:0]             next_idx_c;
    logic [DATA_W-1:0]      scale_src_c;
    logic [WIDE_W-1:0]      prod_c;
    logic [DATA_W-1:0]      scaled_c;

    // Divider is launched on the accept edge so its iterations line up
    // with the DIVIDE state; a zero magnitude skips it entirely.
    always_comb begin
        accept_c    = (state == IDLE) && in_valid && in_ready;
        div_start_c = accept_c && (magnitude != '0);
    end

    seq_restoring_divider #(
        .NUM_W_P (NUM_W),
        .DEN_W_P (DATA_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start_c),
        .numerator   ({target, FRAC_W'(0)}),
        .denominator (magnitude),
        .done        (div_done),
        .quotient    (div_quotient)
    );

    // Single shared scaler: sample0 in LOAD, the following sample in EMIT
    always_comb begin
        next_idx_c  = (state == EMIT) ? out_index + 2'd1 : 2'd0;
        scale_src_c = frame_q[next_idx_c];
        prod_c      = WIDE_W'(scale_src_c) * WIDE_W'(gain_q);
`ifdef RSS_GAIN_ROUND_EN
        prod_c      = prod_c + WIDE_W'(ROUND_HALF);
`endif
        scaled_c    = sat_narrow(prod_c >> FRAC_W);
    end

    // Control FSM with registered handshake and output signals
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_index  <= 2'd0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            gain_q     <= '0;
            frame_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        frame_q  <= {sample3, sample2, sample1, sample0};
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (magnitude == '0) begin
                            gain_q <= DATA_W'(1) << FRAC_W;
                            state  <= LOAD;
                        end else begin
                            state  <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        gain_q <= sat_narrow(WIDE_W'(div_quotient));
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    out_sample <= scaled_c;
                    out_index  <= 2'd0;
                    out_last   <= 1'b0;
                    out_valid  <= 1'b1;
                    state      <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_index == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_index <= 2'd0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_index  <= next_idx_c;
                            out_sample <= scaled_c;
                            out_last   <= (next_idx_c == 2'd3);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rss_gain_normalizer.sv
// Self-checking bench for rss_gain_normalizer: directed frames from the
// test plan plus randomized frames, all compared against an arithmetic
// model of gain and scaling.
module tb_rss_gain_normalizer;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] sample0;
    logic [DW-1:0] sample1;
    logic [DW-1:0] sample2;
    logic [DW-1:0] sample3;
    logic [DW-1:0] magnitude;
    logic [DW-1:0] target;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sample;
    logic [1:0]    out_index;
    logic          out_last;
    logic          busy;

    int n_checks;
    int n_errors;
    int cyc;

    rss_gain_normalizer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sample0    (sample0),
        .sample1    (sample1),
        .sample2    (sample2),
        .sample3    (sample3),
        .magnitude  (magnitude),
        .target     (target),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: gain = min((target * 2^16) / magnitude, 2^32-1), 1.0 if magnitude is 0
    function automatic longint unsigned model_gain(input longint unsigned mag, input longint unsigned tgt);
        longint unsigned q;
        if (mag == 0) return 64'd65536;
        q = (tgt * 64'd65536) / mag;
        if (q > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
        return q;
    endfunction

    // Reference: scaled = min((s * gain [+ 2^15]) / 2^16, 2^32-1)
    function automatic longint unsigned model_scale(input longint unsigned s, input longint unsigned g);
        longint unsigned p;
        p = s * g;
`ifdef RSS_GAIN_ROUND_EN
        p = p + 64'd32768;
`endif
        p = p / 64'd65536;
        if (p > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
        return p;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_out_valid"},  64'(out_valid),  64'd0);
        check({tag, "_out_sample"}, 64'(out_sample), 64'd0);
        check({tag, "_out_index"},  64'(out_index),  64'd0);
        check({tag, "_out_last"},   64'(out_last),   64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
    endtask

    // Idle for a while and confirm nothing leaks out of a discarded frame
    task automatic check_quiet(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (60) begin
            step();
            if (out_valid || busy) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    // Offer one frame and follow it through; rst_at >= 0 aborts it with a
    // one-cycle reset asserted during that cycle number.
    task automatic run_frame(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                             input logic [DW-1:0] s2, input logic [DW-1:0] s3,
                             input logic [DW-1:0] mag, input logic [DW-1:0] tgt,
                             input int stall, input bit rand_ready, input int rst_at);
        longint unsigned g;
        longint unsigned exp_s [4];
        int lat;
        int k;
        int waited;
        bit seen_early;

        g = model_gain(64'(mag), 64'(tgt));
        exp_s[0] = model_scale(64'(s0), g);
        exp_s[1] = model_scale(64'(s1), g);
        exp_s[2] = model_scale(64'(s2), g);
        exp_s[3] = model_scale(64'(s3), g);
        lat = (mag == '0) ? 2 : 50;

        waited = 0;
        while (!in_ready && waited < 100) begin
            step();
            waited++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        if (!in_ready) return;

        sample0 = s0; sample1 = s1; sample2 = s2; sample3 = s3;
        magnitude = mag; target = tgt;
        in_valid = 1'b1;
        out_ready = 1'b0;
        cyc = 0;
        step();
        in_valid = 1'b0;
        // Scramble the inputs: only the accept-cycle values may matter
        sample0 = $urandom; sample1 = $urandom; sample2 = $urandom; sample3 = $urandom;
        magnitude = $urandom; target = $urandom;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_after_accept", 64'(in_ready), 64'd0);

        k = 0;
        seen_early = 1'b0;
        while (k < 4 && cyc < 400) begin
            if (cyc == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_reset_state("mid_rst");
                step();
                check("mid_rst_ready_back", 64'(in_ready), 64'd1);
                check_quiet("mid_rst_no_stale");
                return;
            end
            if (cyc == lat - 1) check("gain", 64'(dut.gain_q), g);
            if (cyc < lat) begin
                if (out_valid) seen_early = 1'b1;
            end else begin
                check("out_valid", 64'(out_valid), 64'd1);
                check("out_sample", 64'(out_sample), exp_s[k]);
                check("out_index", 64'(out_index), 64'(k));
                check("out_last", 64'(out_last), 64'(k == 3));
                if (!rand_ready && cyc >= lat + stall)
                    check("slot_cycle", 64'(cyc), 64'(lat + stall + k));
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : (cyc >= lat + stall);
                if (out_ready) k++;
            end
            step();
        end
        out_ready = 1'b0;
        check("no_early_valid", 64'(seen_early), 64'd0);
        check("frame_complete", 64'(k), 64'd4);
        check("post_out_valid", 64'(out_valid), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sample0 = '0; sample1 = '0; sample2 = '0; sample3 = '0;
        magnitude = '0; target = '0;

        repeat (3) step();
        check_reset_state("reset");
        rst = 1'b0;
        step();
        check("reset_ready_after", 64'(in_ready), 64'd1);

        // Nominal, backpressure, zero magnitude, saturation, rounding
        run_frame(32'd3, 32'd4, 32'd0, 32'd0, 32'd5, 32'd10, 0, 1'b0, -1);
        run_frame(32'd3, 32'd4, 32'd0, 32'd0, 32'd5, 32'd10, 3, 1'b0, -1);
        run_frame(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd100, 0, 1'b0, -1);
        run_frame(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 1'b0, -1);
        run_frame(32'd3, 32'd0, 32'd0, 32'd0, 32'd3, 32'd1, 0, 1'b0, -1);

        // Reset in DIVIDE, then in EMIT after two outputs, each followed by a clean frame
        run_frame(32'd3, 32'd4, 32'd0, 32'd0, 32'd5, 32'd10, 0, 1'b0, 20);
        run_frame(32'd3, 32'd4, 32'd0, 32'd0, 32'd5, 32'd10, 0, 1'b0, -1);
        run_frame(32'd3, 32'd4, 32'd0, 32'd0, 32'd5, 32'd10, 0, 1'b0, 52);
        run_frame(32'd7, 32'd9, 32'd11, 32'd13, 32'd20, 32'd40, 0, 1'b0, -1);

        // Reset coincident with in_valid must not accept the frame
        sample0 = 32'd5; magnitude = 32'd5; target = 32'd5;
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        check_reset_state("rst_with_valid");
        check_quiet("rst_with_valid_no_frame");

        // Randomized frames with random backpressure
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] rs [4];
            logic [DW-1:0] rmag;
            logic [DW-1:0] rtgt;
            for (int j = 0; j < 4; j++) rs[j] = $urandom >> $urandom_range(0, 31);
            rmag = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            rtgt = $urandom >> $urandom_range(0, 31);
            run_frame(rs[0], rs[1], rs[2], rs[3], rmag, rtgt, 0, 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
